// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl: hunts for a sync byte, stores FRAME_LEN payload bytes into
// the frame RAM, guards the frame with an inter-byte timeout and hands the
// finished frame to the consumer through frame_ready/frame_ack.
// Optional feature macro: UART_FRAME_CKSUM_EN (trailing mod-256 checksum byte).
module uart_frame_ctrl #(
  parameter int unsigned FRAME_LEN   = 113,
  parameter logic [7:0]  SYNC_BYTE   = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 20000,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk_Rx,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              frame_ready,
  input  logic              frame_ack,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

`ifdef UART_FRAME_CKSUM_EN
  typedef enum logic [1:0] {HUNT = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {HUNT = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_e;
`endif

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              frame_ready_q, frame_ready_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;

  logic sync_hit;
  logic last_byte;
  logic tmo_exp;

  assign sync_hit  = rx_valid && (rx_data == SYNC_BYTE);
  assign last_byte = (cnt_q == LAST_ADDR);
  assign tmo_exp   = (tmo_q == TMO_LAST);

`ifdef UART_FRAME_CKSUM_EN
  logic [7:0] sum_q, sum_d;
  logic       ck_ok;
  assign ck_ok = (rx_data == sum_q);
`endif

  // State register
  always_ff @(posedge clk_Rx or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a byte arriving on the expiry cycle beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HUNT: begin
        if (sync_hit) state_d = LOAD;
      end
      LOAD: begin
        if (rx_valid) begin
`ifdef UART_FRAME_CKSUM_EN
          if (last_byte) state_d = CHECK;
`else
          if (last_byte) state_d = DONE;
`endif
        end else if (tmo_exp) begin
          state_d = HUNT;
        end
      end
`ifdef UART_FRAME_CKSUM_EN
      CHECK: begin
        if (rx_valid)     state_d = ck_ok ? DONE : HUNT;
        else if (tmo_exp) state_d = HUNT;
      end
`endif
      DONE: begin
        if (frame_ack) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cnt_d       = cnt_q;
    tmo_d       = '0;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
`ifdef UART_FRAME_CKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      HUNT: begin
        if (sync_hit) begin
          cnt_d       = '0;
          frame_err_d = 1'b0;
`ifdef UART_FRAME_CKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      LOAD: begin
        if (rx_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = cnt_q;
          mem_wdata_d = rx_data;
          cnt_d       = cnt_q + ADDR_W'(1);
`ifdef UART_FRAME_CKSUM_EN
          sum_d       = sum_q + rx_data;
`endif
        end else if (tmo_exp) begin
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`ifdef UART_FRAME_CKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (!ck_ok) frame_err_d = 1'b1;
        end else if (tmo_exp) begin
          frame_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
`endif
      DONE: begin
        if (frame_ack)     overrun_d = 1'b0;
        else if (rx_valid) overrun_d = 1'b1;
      end
      default: ;
    endcase
    frame_ready_d = (state_q == DONE) && !frame_ack;
`ifdef UART_FRAME_CKSUM_EN
    busy_d = (state_d == LOAD) || (state_d == CHECK);
`else
    busy_d = (state_d == LOAD);
`endif
  end

  // Datapath and output registers
  always_ff @(posedge clk_Rx or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      tmo_q         <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef UART_FRAME_CKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      frame_ready_q <= frame_ready_d;
      frame_err_q   <= frame_err_d;
      overrun_q     <= overrun_d;
      busy_q        <= busy_d;
`ifdef UART_FRAME_CKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign frame_ready = frame_ready_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Testbench for uart_frame_ctrl: table of frame scenarios with randomized
// payloads, expected RAM writes derived from the sent byte stream, plus
// hand-written sequences for timeout boundary, ack/byte collision and reset.
module tb_uart_frame_ctrl;

  localparam int FL  = 113;
  localparam int TMO = 120;
  localparam int AW  = 8;
  localparam logic [7:0] SYNC = 8'hAA;
`ifdef UART_FRAME_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic          clk_Rx;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          frame_ready;
  logic          frame_ack;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  uart_frame_ctrl #(
    .FRAME_LEN  (FL),
    .SYNC_BYTE  (SYNC),
    .TIMEOUT_CYC(TMO),
    .ADDR_W     (AW)
  ) dut (
    .clk_Rx     (clk_Rx),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .frame_ready(frame_ready),
    .frame_ack  (frame_ack),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk_Rx = 1'b0;
  always #5 clk_Rx = ~clk_Rx;

  typedef struct {
    int n_noise;
    int n_bytes;
    int gap;        // idle cycles between bytes, -1 = random 0..3
    bit incr;       // payload = address pattern instead of random
    int n_extra;    // bytes sent while the frame waits for ack
    bit exp_ready;
    bit exp_err;
    bit exp_ovr;
  } vec_t;

  vec_t vecs[7];

  int errors = 0;
  int checks = 0;

  logic [AW+7:0] wr_q[$];   // every observed RAM write {addr, data}
  logic [7:0]    pay_q[$];  // payload bytes sent for the current frame
  int            wr_base;

  // Record RAM writes mid-cycle
  always @(negedge clk_Rx) begin
    if (mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
  end

  task automatic tick();
    @(posedge clk_Rx);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick_gap(input int g);
    return (g < 0) ? int'($urandom_range(0, 3)) : g;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat (gap) tick();
  endtask

  // Sends n payload bytes (and the checksum byte for a full frame when enabled)
  task automatic send_payload(input int n, input int gap, input bit incr, input bit bad_ck);
    logic [7:0] b;
    logic [7:0] sum;
    pay_q.delete();
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = incr ? 8'(i) : 8'($urandom);
      pay_q.push_back(b);
      sum = sum + b;
      send_byte(b, pick_gap(gap));
    end
    if (CK && n == FL) send_byte(bad_ck ? sum + 8'd1 : sum, pick_gap(gap));
  endtask

  // Compares the writes seen since wr_base against the payload sent
  task automatic check_writes(input string tag, input int n_exp);
    chk({tag, "_wr_count"}, 32'(wr_q.size() - wr_base), 32'(n_exp));
    for (int i = 0; i < n_exp; i++) begin
      if (wr_base + i < wr_q.size())
        chk({tag, "_wr"}, 32'(wr_q[wr_base + i]), 32'({AW'(i), pay_q[i]}));
    end
  endtask

  task automatic send_sync();
    send_byte(SYNC, 0);
    chk("sync_clears_err", 32'(frame_err), 32'd0);
    chk("sync_busy", 32'(busy), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [7:0] b;
    int n_wr;
    string tag;
    tag = $sformatf("vec%0d", idx);
    wr_base = wr_q.size();
    for (int i = 0; i < v.n_noise; i++) begin
      do b = 8'($urandom); while (b == SYNC);
      send_byte(b, int'($urandom_range(0, 3)));
    end
    send_sync();
    send_payload(v.n_bytes, v.gap, v.incr, 1'b0);
    if (v.n_bytes >= FL) repeat (3) tick();
    else repeat (TMO + 2) tick();
    for (int e = 0; e < v.n_extra; e++) send_byte(8'($urandom), 1);
    n_wr = (v.n_bytes < FL) ? v.n_bytes : FL;
    check_writes(tag, n_wr);
    chk({tag, "_ready"}, 32'(frame_ready), 32'(v.exp_ready));
    chk({tag, "_err"}, 32'(frame_err), 32'(v.exp_err));
    chk({tag, "_ovr"}, 32'(overrun), 32'(v.exp_ovr));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    if (v.exp_ready) begin
      frame_ack = 1'b1;
      tick();
      frame_ack = 1'b0;
      chk({tag, "_ack_ready"}, 32'(frame_ready), 32'd0);
      chk({tag, "_ack_ovr"}, 32'(overrun), 32'd0);
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_ready"}, 32'(frame_ready), 32'd0);
    chk({tag, "_err"}, 32'(frame_err), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{0, FL, 100,     1'b1, 0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{2, FL, -1,      1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{0, 10, 2,       1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1, FL, -1,      1'b0, 2, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{0, FL, 0,       1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3, 1,  0,       1'b0, 0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{0, FL, TMO - 1, 1'b0, 0, 1'b1, 1'b0, 1'b0};

    rst       = 1'b1;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    frame_ack = 1'b0;
    wr_base   = 0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Silence of exactly TIMEOUT_CYC cycles after a byte: alive one cycle before, error after
    send_sync();
    send_payload(5, 0, 1'b0, 1'b0);
    repeat (TMO - 1) tick();
    chk("tmo_edge_err", 32'(frame_err), 32'd0);
    chk("tmo_edge_busy", 32'(busy), 32'd1);
    tick();
    chk("tmo_hit_err", 32'(frame_err), 32'd1);
    chk("tmo_hit_busy", 32'(busy), 32'd0);
    chk("tmo_hit_ready", 32'(frame_ready), 32'd0);

    // frame_ack and a sync byte in the same DONE cycle: ack wins, byte dropped
    wr_base = wr_q.size();
    send_sync();
    send_payload(FL, 0, 1'b0, 1'b0);
    repeat (3) tick();
    chk("collide_ready_before", 32'(frame_ready), 32'd1);
    frame_ack = 1'b1;
    rx_valid  = 1'b1;
    rx_data   = SYNC;
    tick();
    frame_ack = 1'b0;
    rx_valid  = 1'b0;
    chk("collide_ready", 32'(frame_ready), 32'd0);
    chk("collide_ovr", 32'(overrun), 32'd0);
    chk("collide_no_sync", 32'(busy), 32'd0);
    send_byte(8'h11, 3);
    check_writes("collide", FL);

`ifdef UART_FRAME_CKSUM_EN
    // Wrong checksum: payload stays in RAM, frame rejected
    wr_base = wr_q.size();
    send_sync();
    send_payload(FL, -1, 1'b1, 1'b1);
    repeat (3) tick();
    check_writes("badck", FL);
    chk("badck_err", 32'(frame_err), 32'd1);
    chk("badck_ready", 32'(frame_ready), 32'd0);
    chk("badck_busy", 32'(busy), 32'd0);
`endif

    // Reset while byte 50 arrives: outputs clear inside the cycle, no further writes
    wr_base = wr_q.size();
    send_sync();
    send_payload(50, 0, 1'b0, 1'b0);
    tick();
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    #2 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    tick();
    rx_valid = 1'b0;
    tick();
    check_writes("rst_mid", 50);
    rst = 1'b0;
    tick();
    run_vec(vecs[1], 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
